// File: rtl/color_effect_engine.sv
// Purpose : per-pixel colour/effect stage; per-frame fade, R->G->B cycle, white and strobe
//           effects, masked to visible foreground pixels.
// Latency : R/G/B registered, 1 cycle after the pixel inputs; effects step on enable & frame_tick.
// Backpressure: none; enable=0 freezes every register (outputs, intensities, FSM, strobe).
// Ports   : clk, reset (async, active-low), enable, frame_tick, display_area, pixel_on,
//           mode[1:0], ch_sel[2:0] {R,G,B}, white_in, strobe_en -> R/G/B[COLOR_W-1:0], strobe_phase.
module color_effect_engine #(
  parameter int COLOR_W    = 3,
  parameter int STEP       = 1,
  parameter int STROBE_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               display_area,
  input  logic               pixel_on,
  input  logic [1:0]         mode,
  input  logic [2:0]         ch_sel,
  input  logic               white_in,
  input  logic               strobe_en,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               strobe_phase
);

  localparam logic [COLOR_W:0] L_MAX  = (COLOR_W+1)'((1 << COLOR_W) - 1);
  localparam logic [COLOR_W:0] L_STEP = (COLOR_W+1)'(STEP);
  localparam int               CNT_W  = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_DIV - 1);

  typedef enum logic [1:0] {CYC_R = 2'd0, CYC_G = 2'd1, CYC_B = 2'd2} cyc_t;

  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [COLOR_W-1:0] r_int [3];
  logic               r_dir [3];       // 1 = counting up
  logic [COLOR_W-1:0] r_out [3];
  logic [CNT_W-1:0]   r_strobe_cnt;
  logic               r_strobe_phase;
  cyc_t               r_cyc;

  logic [COLOR_W-1:0] w_int_nxt [3];
  logic               w_dir_nxt [3];
  cyc_t               w_cyc_nxt;
  logic [COLOR_W:0]   w_up      [3];
  logic [COLOR_W:0]   w_dn      [3];
  logic [COLOR_W-1:0] w_stp_int [3];
  logic               w_stp_dir [3];
  logic               w_hit0    [3];
  logic               w_show;

  // Saturating one-step result per channel, evaluated one bit wider so the
  // up-step can never wrap before it is compared against MAX.
  for (genvar i = 0; i < 3; i++) begin : g_step
    logic w_sat_up;
    assign w_up[i]      = {1'b0, r_int[i]} + L_STEP;
    assign w_dn[i]      = {1'b0, r_int[i]} - L_STEP;
    assign w_sat_up     = (w_up[i] >= L_MAX);
    assign w_hit0[i]    = ~r_dir[i] & ({1'b0, r_int[i]} <= L_STEP);
    assign w_stp_int[i] = r_dir[i] ? (w_sat_up ? L_MAX[COLOR_W-1:0] : w_up[i][COLOR_W-1:0])
                                   : (w_hit0[i] ? '0 : w_dn[i][COLOR_W-1:0]);
    assign w_stp_dir[i] = r_dir[i] ? ~w_sat_up : w_hit0[i];
  end

  // Effect next-state: white overrides every mode; the cycle FSM only moves
  // on when its own channel's down-step reaches zero.
  always_comb begin
    w_int_nxt = r_int;
    w_dir_nxt = r_dir;
    w_cyc_nxt = r_cyc;
    if (frame_tick) begin
      if (white_in) begin
        for (int i = 0; i < 3; i++) begin
          w_int_nxt[i] = L_MAX[COLOR_W-1:0];
          w_dir_nxt[i] = 1'b0;
        end
      end else begin
        case (mode)
          2'b01: begin
            for (int i = 0; i < 3; i++) begin
              if (ch_sel[2-i]) begin
                w_int_nxt[i] = w_stp_int[i];
                w_dir_nxt[i] = w_stp_dir[i];
              end
            end
          end
          2'b10: begin
            case (r_cyc)
              CYC_R: begin
                w_int_nxt[0] = w_stp_int[0];
                w_dir_nxt[0] = w_stp_dir[0];
                if (w_hit0[0]) w_cyc_nxt = CYC_G;
              end
              CYC_G: begin
                w_int_nxt[1] = w_stp_int[1];
                w_dir_nxt[1] = w_stp_dir[1];
                if (w_hit0[1]) w_cyc_nxt = CYC_B;
              end
              CYC_B: begin
                w_int_nxt[2] = w_stp_int[2];
                w_dir_nxt[2] = w_stp_dir[2];
                if (w_hit0[2]) w_cyc_nxt = CYC_R;
              end
              default: w_cyc_nxt = CYC_R;
            endcase
          end
          default: w_cyc_nxt = CYC_R;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc <= CYC_R;
    end else if (enable) begin
      r_cyc <= w_cyc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        r_int[i] <= '0;
        r_dir[i] <= 1'b1;
      end
    end else if (enable) begin
      r_int <= w_int_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_strobe_cnt   <= '0;
      r_strobe_phase <= 1'b0;
    end else if (enable && frame_tick) begin
      if (!strobe_en) begin
        r_strobe_cnt   <= '0;
        r_strobe_phase <= 1'b0;
      end else if (r_strobe_cnt == CNT_LAST) begin
        r_strobe_cnt   <= '0;
        r_strobe_phase <= ~r_strobe_phase;
      end else begin
        r_strobe_cnt <= r_strobe_cnt + 1'b1;
      end
    end
  end

  // Output samples the pre-tick intensities and strobe phase.
  assign w_show = display_area & pixel_on & ~(strobe_en & r_strobe_phase);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) r_out[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < 3; i++) r_out[i] <= w_show ? r_int[i] : '0;
    end
  end

  assign R            = r_out[0];
  assign G            = r_out[1];
  assign B            = r_out[2];
  assign strobe_phase = r_strobe_phase;

endmodule

// File: tb/tb_color_effect_engine.sv
// Purpose : bench for color_effect_engine; two instances (STEP=1/DIV=4 and STEP=3/DIV=2)
//           share one stimulus stream and are checked every cycle against a behavioural model.
// Latency : model mirrors 1-cycle output latency; no backpressure involved.
module tb_color_effect_engine;

  localparam int MAXV = 7;
  localparam int NCFG = 2;
  int steps [NCFG] = '{1, 3};
  int divs  [NCFG] = '{4, 2};

  logic clk = 1'b0;
  logic reset, enable, frame_tick, display_area, pixel_on, white_in, strobe_en;
  logic [1:0] mode;
  logic [2:0] ch_sel;
  logic [2:0] r1, g1, b1, r2, g2, b2;
  logic       p1, p2;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  color_effect_engine #(.COLOR_W(3), .STEP(1), .STROBE_DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .display_area(display_area), .pixel_on(pixel_on), .mode(mode), .ch_sel(ch_sel),
    .white_in(white_in), .strobe_en(strobe_en), .R(r1), .G(g1), .B(b1), .strobe_phase(p1));

  color_effect_engine #(.COLOR_W(3), .STEP(3), .STROBE_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .display_area(display_area), .pixel_on(pixel_on), .mode(mode), .ch_sel(ch_sel),
    .white_in(white_in), .strobe_en(strobe_en), .R(r2), .G(g2), .B(b2), .strobe_phase(p2));

  // ---------------- behavioural model ----------------
  int m_int   [NCFG][3];
  int m_up    [NCFG][3];
  int m_out   [NCFG][3];
  int m_ch    [NCFG];
  int m_cnt   [NCFG];
  int m_phase [NCFG];

  // One saturating step of channel k; returns 1 when a down-step lands on zero.
  function automatic bit model_step(int c, int k);
    int v;
    if (m_up[c][k] != 0) begin
      v = m_int[c][k] + steps[c];
      if (v >= MAXV) begin m_int[c][k] = MAXV; m_up[c][k] = 0; end
      else m_int[c][k] = v;
      return 1'b0;
    end
    if (m_int[c][k] <= steps[c]) begin
      m_int[c][k] = 0; m_up[c][k] = 1;
      return 1'b1;
    end
    m_int[c][k] = m_int[c][k] - steps[c];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int c = 0; c < NCFG; c++) begin
      if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          m_int[c][k] = 0; m_up[c][k] = 1; m_out[c][k] = 0;
        end
        m_ch[c] = 0; m_cnt[c] = 0; m_phase[c] = 0;
      end else if (enable) begin
        for (int k = 0; k < 3; k++)
          m_out[c][k] = (display_area && pixel_on && !(strobe_en && m_phase[c] != 0)) ? m_int[c][k] : 0;
        if (frame_tick) begin
          if (!strobe_en) begin
            m_cnt[c] = 0; m_phase[c] = 0;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
            if (m_cnt[c] >= divs[c]) begin m_cnt[c] = 0; m_phase[c] = 1 - m_phase[c]; end
          end
          if (white_in) begin
            for (int k = 0; k < 3; k++) begin m_int[c][k] = MAXV; m_up[c][k] = 0; end
          end else if (mode == 2'b01) begin
            for (int k = 0; k < 3; k++)
              if (ch_sel[2-k]) void'(model_step(c, k));
          end else if (mode == 2'b10) begin
            if (model_step(c, m_ch[c])) m_ch[c] = (m_ch[c] + 1) % 3;
          end else begin
            m_ch[c] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("R1", int'(r1), m_out[0][0]);
      chk("G1", int'(g1), m_out[0][1]);
      chk("B1", int'(b1), m_out[0][2]);
      chk("PH1", int'(p1), m_phase[0]);
      chk("R2", int'(r2), m_out[1][0]);
      chk("G2", int'(g2), m_out[1][1]);
      chk("B2", int'(b2), m_out[1][2]);
      chk("PH2", int'(p2), m_phase[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic randomize_inputs(input bit keep_reset);
    if (!keep_reset) reset = ($urandom_range(0, 299) != 0);
    enable       = ($urandom_range(0, 7) != 0);
    frame_tick   = ($urandom_range(0, 2) == 0);
    display_area = $urandom_range(0, 1) != 0;
    pixel_on     = $urandom_range(0, 3) != 0;
    mode         = $urandom_range(0, 1) != 0 ? 2'b10 : 2'($urandom_range(0, 3));
    ch_sel       = 3'($urandom_range(0, 7));
    white_in     = ($urandom_range(0, 11) == 0);
    strobe_en    = ($urandom_range(0, 3) != 0);
  endtask

  int exp1 [8] = '{1, 2, 3, 4, 5, 6, 7, 6};
  int exp2 [8] = '{3, 6, 7, 4, 1, 0, 3, 6};
  int ph1  [4] = '{0, 0, 0, 1};
  int ph2  [4] = '{0, 1, 1, 0};

  initial begin
    reset = 1'b0;
    randomize_inputs(1'b1);
    step();
    chk_on = 1'b1;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      randomize_inputs(1'b1);
      step();
      chk("rst_R1", int'(r1), 0);
      chk("rst_PH2", int'(p2), 0);
    end

    enable = 1'b1; frame_tick = 1'b0; display_area = 1'b1; pixel_on = 1'b1;
    white_in = 1'b0; strobe_en = 1'b0; mode = 2'b01; ch_sel = 3'b100;
    step();
    reset = 1'b1;
    step();

    // Red-only fade, both step sizes.
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fade_R1", int'(r1), exp1[k]);
      chk("fade_R2", int'(r2), exp2[k]);
      chk("fade_G1", int'(g1), 0);
    end

    // White override, then fade resumes downward from MAX.
    white_in = 1'b1;
    tick();
    white_in = 1'b0;
    chk("white_R1", int'(r1), 7);
    chk("white_B1", int'(b1), 7);
    tick();
    chk("postw_R1", int'(r1), 6);
    chk("postw_G1", int'(g1), 7);

    // enable=0 freezes everything even with ticks.
    enable = 1'b0;
    display_area = 1'b0;
    tick();
    tick();
    chk("frz_R1", int'(r1), 6);
    enable = 1'b1;
    display_area = 1'b1;
    step();
    chk("unfrz_R1", int'(r1), 6);
    display_area = 1'b0;
    step();
    chk("blank_R1", int'(r1), 0);
    display_area = 1'b1;

    // Colour cycle: red up and down, then green starts.
    pulse_reset();
    mode = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("cyc_R1", int'(r1), (k <= 7) ? k : 14 - k);
      chk("cyc_G1", int'(g1), 0);
    end
    tick();
    chk("cyc15_G1", int'(g1), 1);
    chk("cyc15_R1", int'(r1), 0);

    // Strobe on white intensities.
    pulse_reset();
    mode = 2'b00;
    white_in = 1'b1;
    tick();
    white_in = 1'b0;
    strobe_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("strb_PH1", int'(p1), ph1[k]);
      chk("strb_PH2", int'(p2), ph2[k]);
      chk("strb_R2", int'(r2), (ph2[k] != 0) ? 0 : 7);
    end
    strobe_en = 1'b0;
    tick();
    chk("strb_off_PH1", int'(p1), 0);
    chk("strb_off_R2", int'(r2), 7);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(1'b0);
      step();
    end

    reset = 1'b1;
    step();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
